// File: rtl/multi_timer.sv
// multi_timer: multi-channel countdown timer on the memory-mapped peripheral bus.
// Each channel has a WIDTH-bit preset/count, an 8-bit prescaler, one-shot or
// auto-reload mode and a sticky write-1-to-clear pending flag.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset    - synchronous, active-high
//   addr     - byte address; addr[5:4] selects channel, addr[3:2] register
//   we       - write enable for the addressed register
//   wdata    - write data
//   rdata    - combinational read of the addressed register (zero-extended)
//   irq_vec  - per-channel pending & IM
//   irq      - OR of irq_vec
//
// Register map per channel:
//   0 CTRL   : [0] EN, [2:1] MODE (01 auto-reload, else one-shot), [3] IM,
//              [15:8] PRESCALE
//   1 PRESET : [WIDTH-1:0]
//   2 COUNT  : [WIDTH-1:0]
//   3 STATUS : [0] pending (W1C), [1] busy, [3:2] state code
module multi_timer #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         addr,
    input  logic                we,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [CHANNELS-1:0] irq_vec,
    output logic                irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t             state_q   [CHANNELS];
    state_t             state_d   [CHANNELS];
    logic               en_q      [CHANNELS];
    logic               en_d      [CHANNELS];
    logic [1:0]         mode_q    [CHANNELS];
    logic [1:0]         mode_d    [CHANNELS];
    logic               im_q      [CHANNELS];
    logic               im_d      [CHANNELS];
    logic [7:0]         psc_q     [CHANNELS];
    logic [7:0]         psc_d     [CHANNELS];
    logic [7:0]         pcnt_q    [CHANNELS];
    logic [7:0]         pcnt_d    [CHANNELS];
    logic [WIDTH-1:0]   preset_q  [CHANNELS];
    logic [WIDTH-1:0]   preset_d  [CHANNELS];
    logic [WIDTH-1:0]   count_q   [CHANNELS];
    logic [WIDTH-1:0]   count_d   [CHANNELS];
    logic               pending_q [CHANNELS];
    logic               pending_d [CHANNELS];

    logic [1:0] sel_ch;
    logic [1:0] sel_reg;
    logic       unused_bits;

    assign sel_ch      = addr[5:4];
    assign sel_reg     = addr[3:2];
    assign unused_bits = ^{addr[31:6], addr[1:0], wdata};

    // Next-state / register update. A bus write to a channel replaces that
    // channel's FSM step for the cycle, so a set of pending by the FSM and a
    // W1C clear can never meet in the same cycle.
    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            state_d[c]   = state_q[c];
            en_d[c]      = en_q[c];
            mode_d[c]    = mode_q[c];
            im_d[c]      = im_q[c];
            psc_d[c]     = psc_q[c];
            pcnt_d[c]    = pcnt_q[c];
            preset_d[c]  = preset_q[c];
            count_d[c]   = count_q[c];
            pending_d[c] = pending_q[c];

            if (we && sel_ch == 2'(c)) begin
                case (sel_reg)
                    2'd0: begin
                        en_d[c]   = wdata[0];
                        mode_d[c] = wdata[2:1];
                        im_d[c]   = wdata[3];
                        psc_d[c]  = wdata[15:8];
                    end
                    2'd1:    preset_d[c] = wdata[WIDTH-1:0];
                    2'd2:    count_d[c]  = wdata[WIDTH-1:0];
                    default: if (wdata[0]) pending_d[c] = 1'b0;
                endcase
            end else begin
                case (state_q[c])
                    S_IDLE: begin
                        if (en_q[c]) state_d[c] = S_LOAD;
                    end
                    S_LOAD: begin
                        count_d[c] = preset_q[c];
                        pcnt_d[c]  = '0;
                        state_d[c] = S_CNT;
                    end
                    S_CNT: begin
                        if (!en_q[c]) begin
                            state_d[c] = S_IDLE;
                        end else if (pcnt_q[c] == psc_q[c]) begin
                            pcnt_d[c] = '0;
                            // COUNT of 0 or 1 both expire, so PRESET=0 acts as 1.
                            if (count_q[c] > WIDTH'(1)) begin
                                count_d[c] = count_q[c] - WIDTH'(1);
                            end else begin
                                count_d[c]   = '0;
                                pending_d[c] = 1'b1;
                                state_d[c]   = S_INT;
                            end
                        end else begin
                            pcnt_d[c] = pcnt_q[c] + 8'd1;
                        end
                    end
                    default: begin
                        if (en_q[c] && mode_q[c] == 2'b01) begin
                            state_d[c] = S_LOAD;
                        end else begin
                            en_d[c]    = 1'b0;
                            state_d[c] = S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (reset) begin
                state_q[c]   <= S_IDLE;
                en_q[c]      <= 1'b0;
                mode_q[c]    <= '0;
                im_q[c]      <= 1'b0;
                psc_q[c]     <= '0;
                pcnt_q[c]    <= '0;
                preset_q[c]  <= '0;
                count_q[c]   <= '0;
                pending_q[c] <= 1'b0;
            end else begin
                state_q[c]   <= state_d[c];
                en_q[c]      <= en_d[c];
                mode_q[c]    <= mode_d[c];
                im_q[c]      <= im_d[c];
                psc_q[c]     <= psc_d[c];
                pcnt_q[c]    <= pcnt_d[c];
                preset_q[c]  <= preset_d[c];
                count_q[c]   <= count_d[c];
                pending_q[c] <= pending_d[c];
            end
        end
    end

    // Channel indices with no channel behind them match no loop iteration
    // and therefore read 0.
    always_comb begin
        rdata = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (sel_ch == 2'(c)) begin
                case (sel_reg)
                    2'd0:    rdata[15:0] = {psc_q[c], 4'b0000, im_q[c], mode_q[c], en_q[c]};
                    2'd1:    rdata[WIDTH-1:0] = preset_q[c];
                    2'd2:    rdata[WIDTH-1:0] = count_q[c];
                    default: rdata[3:0] = {state_q[c], (state_q[c] != S_IDLE), pending_q[c]};
                endcase
            end
        end
    end

    always_comb begin
        irq_vec = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            irq_vec[c] = pending_q[c] & im_q[c];
        end
    end

    assign irq = |irq_vec;

endmodule
